// File: rtl/spi_minion_mc_pkg.sv
// Shared types and frame-field helpers for the multi-channel SPI minion adapter.
// A frame data field is {chan[CW-1:0], payload[PW-1:0]}; helpers work on a wide carrier and are sized at the call site.
package spi_minion_mc_pkg;

   localparam int MAX_CW = 8;
   localparam int MAX_FW = 64;

   typedef logic [MAX_CW-1:0] chan_t;
   typedef logic [MAX_FW-1:0] field_t;

   function automatic int calc_cw(input int nchan);
      return $clog2(nchan);
   endfunction

   function automatic int calc_pw(input int nbits, input int nchan);
      return nbits - 2 - calc_cw(nchan);
   endfunction

   function automatic field_t payload_mask(input int pw);
      return (field_t'(1) << pw) - field_t'(1);
   endfunction

   function automatic chan_t frame_chan(input field_t f, input int pw);
      return chan_t'(f >> pw);
   endfunction

   function automatic field_t frame_payload(input field_t f, input int pw);
      return f & payload_mask(pw);
   endfunction

   function automatic field_t frame_pack(input chan_t c, input field_t p, input int pw);
      return (field_t'(c) << pw) | (p & payload_mask(pw));
   endfunction

endpackage

// File: rtl/fifo.sv
// Generic val/rdy queue, no bypass: one-cycle minimum latency, simultaneous enq/deq when neither empty nor full.
// in_rdy is low only when full; out_vld and count come straight from registered occupancy.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [W-1:0]               in_dat,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [W-1:0]               out_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic            enq;
   logic            deq;

   function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
   endfunction

   assign in_rdy  = (count != CNTW'(DEPTH));
   assign out_vld = (count != '0);
   assign out_dat = mem[rd_ptr];
   assign enq     = in_vld & in_rdy;
   assign deq     = out_vld & out_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= next_ptr(wr_ptr);
         if (deq) rd_ptr <= next_ptr(rd_ptr);
         if (enq && !deq)      count <= count + CNTW'(1);
         else if (deq && !enq) count <= count - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= in_dat;
   end

endmodule

// File: rtl/spi_helpers_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant from the first request at or after rr, wrapping.
// rr moves past the granted channel only when the grant is consumed (advance), otherwise it holds.
module spi_helpers_rr_arbiter #(
   parameter int N  = 4,
   parameter int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [CW-1:0] gnt,
   output logic          any
);
   logic [CW-1:0] rr;
   logic [CW-1:0] idx;

   // Scan from farthest to nearest so the channel closest to rr wins.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = CW'((int'(rr) + i) % N);
         if (req[idx]) begin
            gnt = idx;
            any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)               rr <= '0;
      else if (advance && any) rr <= (gnt == CW'(N - 1)) ? '0 : gnt + CW'(1);
   end

endmodule

// File: rtl/spi_helpers_minion_adapter_mc.sv
// Multi-channel SPI minion adapter: push frames steer into per-channel write queues, pulls round-robin over read queues.
// Queues add one cycle; writes to a full queue drop (pull_msg_spc warns ahead). Option: SPI_MINION_ADAPTER_PARITY_EN.
module spi_helpers_minion_adapter_mc
   import spi_minion_mc_pkg::*;
#(
   parameter  int NBITS = 8,
   parameter  int NCHAN = 4,
   parameter  int DEPTH = 2,
   localparam int CW    = calc_cw(NCHAN),
   localparam int PW    = calc_pw(NBITS, NCHAN)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push_en,
   input  logic                push_msg_val_wrt,
   input  logic                push_msg_val_rd,
   input  logic [NBITS-3:0]    push_msg_data,
   input  logic                pull_en,
   output logic                pull_msg_val,
   output logic                pull_msg_spc,
   output logic [NBITS-3:0]    pull_msg_data,
   input  logic [NCHAN*PW-1:0] recv_msg,
   input  logic [NCHAN-1:0]    recv_val,
   output logic [NCHAN-1:0]    recv_rdy,
   output logic [NCHAN*PW-1:0] send_msg,
   output logic [NCHAN-1:0]    send_val,
   input  logic [NCHAN-1:0]    send_rdy,
`ifdef SPI_MINION_ADAPTER_PARITY_EN
   output logic [NCHAN-1:0]    parity,
`endif
   output logic                err_bad_chan
);
   localparam int FW   = NBITS - 2;
   localparam int CNTW = $clog2(DEPTH + 1);

   if (NCHAN < 2) begin : g_chk_nchan
      $error("NCHAN must be at least 2");
   end
   if (DEPTH < 1) begin : g_chk_depth
      $error("DEPTH must be at least 1");
   end
   if (PW < 1) begin : g_chk_pw
      $error("NBITS too small: no payload bits left after the channel field");
   end

   logic              wr;
   logic [CW-1:0]     wr_chan;
   logic [PW-1:0]     wr_pay;
   logic              wr_chan_ok;
   logic [NCHAN-1:0]  wq_wr;
   logic [NCHAN-1:0]  wq_spc;
   logic [CNTW-1:0]   wq_cnt [NCHAN];
   logic [CNTW-1:0]   rq_cnt_unused [NCHAN];
   logic [NCHAN-1:0]  rq_vld;
   logic [NCHAN-1:0]  rq_rdy;
   logic [PW-1:0]     rq_dat [NCHAN];
   logic [CW-1:0]     gnt;
   logic              gnt_any;

   assign wr         = push_en & push_msg_val_wrt;
   assign wr_chan    = CW'(frame_chan(field_t'(push_msg_data), PW));
   assign wr_pay     = PW'(frame_payload(field_t'(push_msg_data), PW));
   assign wr_chan_ok = ({1'b0, wr_chan} < (CW + 1)'(NCHAN));

   for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      assign wq_wr[c] = wr & wr_chan_ok & (wr_chan == CW'(c));
      // Space for the frame after this one: two free, or one free that this frame is not taking.
      assign wq_spc[c] = (int'(wq_cnt[c]) + 2 <= DEPTH) ||
                         ((int'(wq_cnt[c]) < DEPTH) && !wq_wr[c]);
      assign rq_rdy[c] = pull_msg_val & (gnt == CW'(c));

      fifo #(.W(PW), .DEPTH(DEPTH)) u_wq (
         .clk     (clk),
         .reset   (reset),
         .in_vld  (wq_wr[c]),
         .in_rdy  (),
         .in_dat  (wr_pay),
         .out_vld (send_val[c]),
         .out_rdy (send_rdy[c]),
         .out_dat (send_msg[c*PW +: PW]),
         .count   (wq_cnt[c])
      );

      fifo #(.W(PW), .DEPTH(DEPTH)) u_rq (
         .clk     (clk),
         .reset   (reset),
         .in_vld  (recv_val[c]),
         .in_rdy  (recv_rdy[c]),
         .in_dat  (recv_msg[c*PW +: PW]),
         .out_vld (rq_vld[c]),
         .out_rdy (rq_rdy[c]),
         .out_dat (rq_dat[c]),
         .count   (rq_cnt_unused[c])
      );

`ifdef SPI_MINION_ADAPTER_PARITY_EN
      assign parity[c] = (^send_msg[c*PW +: PW]) & send_val[c];
`endif
   end

   assign pull_msg_spc = &wq_spc;

   spi_helpers_rr_arbiter #(.N(NCHAN), .CW(CW)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (rq_vld),
      .advance (pull_msg_val),
      .gnt     (gnt),
      .any     (gnt_any)
   );

   assign pull_msg_val  = pull_en & push_msg_val_rd & gnt_any;
   assign pull_msg_data = pull_msg_val ?
                          FW'(frame_pack(chan_t'(gnt), field_t'(rq_dat[gnt]), PW)) : '0;

   always_ff @(posedge clk) begin
      if (reset)                 err_bad_chan <= 1'b0;
      else if (wr && !wr_chan_ok) err_bad_chan <= 1'b1;
   end

endmodule

// File: tb/tb_spi_helpers_minion_adapter_mc.sv
// Bench for the multi-channel SPI minion adapter: scoreboard queues for send/pull traffic plus directed state checks.
module tb_spi_helpers_minion_adapter_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        push_en, push_msg_val_wrt, push_msg_val_rd, pull_en;
   logic [7:0]  push_msg_data;
   logic        pull_msg_val, pull_msg_spc;
   logic [7:0]  pull_msg_data;
   logic [23:0] recv_msg;
   logic [3:0]  recv_val, recv_rdy;
   logic [23:0] send_msg;
   logic [3:0]  send_val, send_rdy;
   logic        err_bad_chan;
`ifdef SPI_MINION_ADAPTER_PARITY_EN
   logic [3:0]  parity;
   logic [2:0]  parity3;
`endif

   logic        push_en3, wrt3;
   logic [7:0]  data3;
   logic        pull_val3, spc3;
   logic [7:0]  pull_data3;
   logic [2:0]  recv_rdy3, send_val3;
   logic [17:0] send_msg3;
   logic        err3;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_send [$];
   logic [8:0] exp_pull [$];
   logic [7:0] mon_s;
   logic [8:0] mon_p;
   logic       spc_mid;

   spi_helpers_minion_adapter_mc #(.NBITS(10), .NCHAN(4), .DEPTH(2)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .push_en          (push_en),
      .push_msg_val_wrt (push_msg_val_wrt),
      .push_msg_val_rd  (push_msg_val_rd),
      .push_msg_data    (push_msg_data),
      .pull_en          (pull_en),
      .pull_msg_val     (pull_msg_val),
      .pull_msg_spc     (pull_msg_spc),
      .pull_msg_data    (pull_msg_data),
      .recv_msg         (recv_msg),
      .recv_val         (recv_val),
      .recv_rdy         (recv_rdy),
      .send_msg         (send_msg),
      .send_val         (send_val),
      .send_rdy         (send_rdy),
`ifdef SPI_MINION_ADAPTER_PARITY_EN
      .parity           (parity),
`endif
      .err_bad_chan     (err_bad_chan)
   );

   // Three channels leave chan=3 unmapped, exercising the bad-channel path.
   spi_helpers_minion_adapter_mc #(.NBITS(10), .NCHAN(3), .DEPTH(2)) u_dut3 (
      .clk              (clk),
      .reset            (reset),
      .push_en          (push_en3),
      .push_msg_val_wrt (wrt3),
      .push_msg_val_rd  (1'b0),
      .push_msg_data    (data3),
      .pull_en          (1'b0),
      .pull_msg_val     (pull_val3),
      .pull_msg_spc     (spc3),
      .pull_msg_data    (pull_data3),
      .recv_msg         (18'h0),
      .recv_val         (3'b000),
      .recv_rdy         (recv_rdy3),
      .send_msg         (send_msg3),
      .send_val         (send_val3),
      .send_rdy         (3'b111),
`ifdef SPI_MINION_ADAPTER_PARITY_EN
      .parity           (parity3),
`endif
      .err_bad_chan     (err3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every core-side transfer and every read frame is matched against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         for (int c = 0; c < 4; c++) begin
            if (send_val[c] && send_rdy[c]) begin
               vectors++;
               if (exp_send.size() == 0) begin
                  miscompares++;
                  $display("FAIL send_unexpected: ch%0d payload 0x%0h, nothing expected", c, send_msg[c*6 +: 6]);
               end else begin
                  mon_s = exp_send.pop_front();
                  if ({2'(c), send_msg[c*6 +: 6]} !== mon_s) begin
                     miscompares++;
                     $display("FAIL send_xfer: got {ch,pay}=0x%0h, expected 0x%0h", {2'(c), send_msg[c*6 +: 6]}, mon_s);
                  end
               end
            end
         end
         if (pull_en && push_msg_val_rd) begin
            vectors++;
            if (exp_pull.size() == 0) begin
               miscompares++;
               $display("FAIL pull_unexpected: val=%0b data=0x%0h, nothing expected", pull_msg_val, pull_msg_data);
            end else begin
               mon_p = exp_pull.pop_front();
               if ({pull_msg_val, pull_msg_data} !== mon_p) begin
                  miscompares++;
                  $display("FAIL pull_frame: got {val,data}=0x%0h, expected 0x%0h", {pull_msg_val, pull_msg_data}, mon_p);
               end
            end
         end
      end
   end

   task automatic wr(input logic [7:0] d, output logic spc_during);
      @(posedge clk); #1;
      push_en = 1'b1; push_msg_val_wrt = 1'b1; push_msg_data = d;
      @(negedge clk);
      spc_during = pull_msg_spc;
      @(posedge clk); #1;
      push_en = 1'b0; push_msg_val_wrt = 1'b0; push_msg_data = '0;
   endtask

   task automatic wr3(input logic [7:0] d);
      @(posedge clk); #1;
      push_en3 = 1'b1; wrt3 = 1'b1; data3 = d;
      @(posedge clk); #1;
      push_en3 = 1'b0; wrt3 = 1'b0; data3 = '0;
   endtask

   task automatic rd(input logic v, input logic [7:0] d);
      @(posedge clk); #1;
      pull_en = 1'b1; push_msg_val_rd = 1'b1;
      exp_pull.push_back({v, d});
      @(posedge clk); #1;
      pull_en = 1'b0; push_msg_val_rd = 1'b0;
   endtask

   task automatic rcv(input logic [3:0] v, input logic [23:0] m);
      @(posedge clk); #1;
      recv_val = v; recv_msg = m;
      @(posedge clk); #1;
      recv_val = '0; recv_msg = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      push_en = 0; push_msg_val_wrt = 0; push_msg_val_rd = 0; pull_en = 0;
      push_msg_data = '0; recv_msg = '0; recv_val = '0; send_rdy = 4'hF;
      push_en3 = 0; wrt3 = 0; data3 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_send_val", 32'(send_val), 32'h0);
      check("rst_pull_val", 32'(pull_msg_val), 32'h0);
      check("rst_pull_data", 32'(pull_msg_data), 32'h0);
      check("rst_recv_rdy", 32'(recv_rdy), 32'hF);
      check("rst_spc", 32'(pull_msg_spc), 32'h1);
      check("rst_err", 32'(err_bad_chan), 32'h0);
      check("rst_recv_rdy3", 32'(recv_rdy3), 32'h7);

      // Steered writes: 0xA5 -> ch2 payload 0x25, 0x3C -> ch0 payload 0x3C
      exp_send.push_back(8'hA5);
      wr(8'hA5, spc_mid);
      @(negedge clk);
      check("steer_ch2_val", 32'(send_val), 32'h4);
      check("steer_ch2_msg", 32'(send_msg[12 +: 6]), 32'h25);
      exp_send.push_back(8'h3C);
      wr(8'h3C, spc_mid);
      @(negedge clk);
      check("steer_ch0_val", 32'(send_val), 32'h1);
      @(negedge clk);
      check("steer_drained", 32'(send_val), 32'h0);

      // Round robin: ch1 0x11, ch3 0x22/0x23, then an empty read
      rcv(4'b1010, {6'h22, 6'h00, 6'h11, 6'h00});
      rcv(4'b1000, {6'h23, 6'h00, 6'h00, 6'h00});
      rd(1'b1, 8'h51);
      rd(1'b1, 8'hE2);
      rd(1'b1, 8'hE3);
      rd(1'b0, 8'h00);
      // rr back at 0 means ch0 wins over ch2
      rcv(4'b0101, {6'h00, 6'h06, 6'h00, 6'h05});
      rd(1'b1, 8'h05);
      rd(1'b1, 8'h86);

      // Full and space on ch1
      @(posedge clk); #1 send_rdy = 4'b1101;
      exp_send.push_back(8'h41);
      wr(8'h41, spc_mid);
      check("spc_first_wr", 32'(spc_mid), 32'h1);
      @(negedge clk);
      check("spc_after_1", 32'(pull_msg_spc), 32'h1);
      exp_send.push_back(8'h42);
      wr(8'h42, spc_mid);
      check("spc_second_wr", 32'(spc_mid), 32'h0);
      @(negedge clk);
      check("spc_full", 32'(pull_msg_spc), 32'h0);
      check("full_send_val", 32'(send_val), 32'h2);
      wr(8'h43, spc_mid);
      check("spc_third_wr", 32'(spc_mid), 32'h0);
      @(posedge clk); #1 send_rdy[1] = 1'b1;
      @(posedge clk); #1 send_rdy[1] = 1'b0;
      @(negedge clk);
      check("spc_recovered", 32'(pull_msg_spc), 32'h1);
      check("full_head_after_pop", 32'(send_msg[6 +: 6]), 32'h02);
      @(posedge clk); #1 send_rdy = 4'hF;
      repeat (2) @(posedge clk);

      // Bad channel on the three-channel instance
      wr3(8'hC1);
      @(negedge clk);
      check("bad_send_val", 32'(send_val3), 32'h0);
      check("bad_err_set", 32'(err3), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bad_err_sticky", 32'(err3), 32'h1);
      check("good_err_clear", 32'(err_bad_chan), 32'h0);
      wr3(8'h95);
      @(negedge clk);
      check("dut3_ch2_val", 32'(send_val3), 32'h4);
      check("dut3_ch2_msg", 32'(send_msg3[12 +: 6]), 32'h15);

      // Reset with two entries in rq[0] and wq[2]
      @(posedge clk); #1 send_rdy = 4'b1011;
      wr(8'h81, spc_mid);
      wr(8'h82, spc_mid);
      rcv(4'b0001, {18'h0, 6'h01});
      rcv(4'b0001, {18'h0, 6'h02});
      @(negedge clk);
      check("pre_rst_recv_rdy", 32'(recv_rdy), 32'hE);
      check("pre_rst_send_val", 32'(send_val), 32'h4);
      check("pre_rst_spc", 32'(pull_msg_spc), 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; send_rdy = 4'hF;
      @(negedge clk);
      check("mid_rst_recv_rdy", 32'(recv_rdy), 32'hF);
      check("mid_rst_send_val", 32'(send_val), 32'h0);
      check("mid_rst_spc", 32'(pull_msg_spc), 32'h1);
      check("mid_rst_err3", 32'(err3), 32'h0);
      rd(1'b0, 8'h00);

`ifdef SPI_MINION_ADAPTER_PARITY_EN
      @(posedge clk); #1 send_rdy = 4'b1110;
      exp_send.push_back(8'h07);
      wr(8'h07, spc_mid);
      @(negedge clk);
      check("parity_odd", 32'(parity), 32'h1);
      @(posedge clk); #1 send_rdy[0] = 1'b1;
      @(posedge clk); #1 send_rdy[0] = 1'b0;
      exp_send.push_back(8'h03);
      wr(8'h03, spc_mid);
      @(negedge clk);
      check("parity_even", 32'(parity), 32'h0);
      check("parity_even_val", 32'(send_val), 32'h1);
      @(posedge clk); #1 send_rdy = 4'hF;
      @(negedge clk);
      check("parity_idle", 32'(parity), 32'h0);
`endif

      repeat (4) @(posedge clk);
      check("send_queue_drained", 32'(exp_send.size()), 32'h0);
      check("pull_queue_drained", 32'(exp_pull.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
